tft_spi_tx_fifo: RTL and testbench

//  Buffered SPI transmitter for the ILI9341 TFT PMOD, sitting between the CPU I/O port 7 decode and the TFT pins.

---
 rtl/tft_spi_tx_fifo_if.sv | 22 ++
 rtl/tft_spi_tx_fifo.sv | 173 +++++++++++++++++
 tb/tb_tft_spi_tx_fifo.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/tft_spi_tx_fifo_if.sv
// Host-side write port of the TFT SPI transmitter: push handshake plus FIFO status.
interface tft_spi_tx_fifo_if #(
   parameter int unsigned DEPTH_LOG2 = 4
);
   logic                wr_valid;
   logic [8:0]          wr_data;
   logic                wr_ready;
   logic [DEPTH_LOG2:0] level;
   logic                idle;
   logic                overflow;
   logic                clr_ovf;

   modport master (
      output wr_valid, wr_data, clr_ovf,
      input  wr_ready, level, idle, overflow
   );

   modport slave (
      input  wr_valid, wr_data, clr_ovf,
      output wr_ready, level, idle, overflow
   );
endinterface

// File: rtl/tft_spi_tx_fifo.sv
// Buffered SPI mode-0 transmitter for the ILI9341 TFT: a 9-bit {D/C, byte} FIFO feeding an MSB-first
// shifter that holds CS low across back-to-back entries.
module tft_spi_tx_fifo #(
   parameter int unsigned DEPTH_LOG2 = 4,
   parameter int unsigned DIV        = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   tft_spi_tx_fifo_if.slave host,
   output logic             spi_clk,
   output logic             spi_mosi,
   output logic             spi_dc,
   output logic             spi_cs_n
);

   localparam int unsigned Depth = 2 ** DEPTH_LOG2;
   localparam int unsigned DivW  = (DIV > 0) ? $clog2(DIV + 1) : 1;

   localparam logic [DEPTH_LOG2:0]   LvlFull = {1'b1, {DEPTH_LOG2{1'b0}}};
   localparam logic [DEPTH_LOG2:0]   LvlOne  = (DEPTH_LOG2 + 1)'(1);
   localparam logic [DEPTH_LOG2-1:0] PtrOne  = DEPTH_LOG2'(1);
   localparam logic [DivW-1:0]       DivLoad = DivW'(DIV);

   typedef enum logic [0:0] {StIdle, StShift} state_e;

   logic [8:0]            mem [Depth];
   logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
   logic [DEPTH_LOG2:0]   level_q, level_d;
   logic                  overflow_q, overflow_d;

   state_e                state_q, state_d;
   logic [DivW-1:0]       div_q, div_d;
   logic                  sck_q, sck_d;
   logic                  cs_n_q, cs_n_d;
   logic                  mosi_q, mosi_d;
   logic                  dc_q, dc_d;
   logic [7:0]            shreg_q, shreg_d;
   logic [3:0]            bitcnt_q, bitcnt_d;

   logic                  push, pop, tick, wr_ready;
   logic [8:0]            rd_entry;

   // Full is judged on the registered level, so a same-cycle pop cannot admit a push.
   assign wr_ready = (level_q != LvlFull);
   assign push     = host.wr_valid & wr_ready;
   assign tick     = (div_q == '0);
   assign rd_entry = mem[rd_ptr_q];

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr_q] <= host.wr_data;
      end
   end

   always_comb begin
      level_d = level_q;
      unique case ({push, pop})
         2'b10:   level_d = level_q + LvlOne;
         2'b01:   level_d = level_q - LvlOne;
         default: level_d = level_q;
      endcase
   end

   always_comb begin
      overflow_d = overflow_q;
      if (host.clr_ovf) begin
         overflow_d = 1'b0;
      end else if (host.wr_valid && !wr_ready) begin
         overflow_d = 1'b1;
      end
   end

   always_comb begin
      state_d  = state_q;
      div_d    = div_q;
      sck_d    = sck_q;
      cs_n_d   = cs_n_q;
      mosi_d   = mosi_q;
      dc_d     = dc_q;
      shreg_d  = shreg_q;
      bitcnt_d = bitcnt_q;
      pop      = 1'b0;

      unique case (state_q)
         StIdle: begin
            sck_d  = 1'b0;
            cs_n_d = 1'b1;
            if (level_q != '0) begin
               pop      = 1'b1;
               cs_n_d   = 1'b0;
               dc_d     = rd_entry[8];
               mosi_d   = rd_entry[7];
               shreg_d  = rd_entry[7:0];
               bitcnt_d = 4'd8;
               div_d    = DivLoad;
               state_d  = StShift;
            end
         end
         StShift: begin
            if (tick) begin
               div_d = DivLoad;
               sck_d = ~sck_q;
               // Falling edge: MOSI/DC only move while SCK is about to be low.
               if (sck_q) begin
                  shreg_d  = {shreg_q[6:0], 1'b0};
                  mosi_d   = shreg_q[6];
                  bitcnt_d = bitcnt_q - 4'd1;
                  if (bitcnt_q == 4'd1) begin
                     if (level_q != '0) begin
                        pop      = 1'b1;
                        dc_d     = rd_entry[8];
                        mosi_d   = rd_entry[7];
                        shreg_d  = rd_entry[7:0];
                        bitcnt_d = 4'd8;
                     end else begin
                        cs_n_d  = 1'b1;
                        state_d = StIdle;
                     end
                  end
               end
            end else begin
               div_d = div_q - DivW'(1);
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         overflow_q <= 1'b0;
         state_q    <= StIdle;
         div_q      <= DivLoad;
         sck_q      <= 1'b0;
         cs_n_q     <= 1'b1;
         mosi_q     <= 1'b0;
         dc_q       <= 1'b0;
         shreg_q    <= '0;
         bitcnt_q   <= '0;
      end else begin
         if (push) begin
            wr_ptr_q <= wr_ptr_q + PtrOne;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PtrOne;
         end
         level_q    <= level_d;
         overflow_q <= overflow_d;
         state_q    <= state_d;
         div_q      <= div_d;
         sck_q      <= sck_d;
         cs_n_q     <= cs_n_d;
         mosi_q     <= mosi_d;
         dc_q       <= dc_d;
         shreg_q    <= shreg_d;
         bitcnt_q   <= bitcnt_d;
      end
   end

   assign host.wr_ready = wr_ready;
   assign host.level    = level_q;
   assign host.overflow = overflow_q;
   assign host.idle     = (state_q == StIdle) && (level_q == '0);

   assign spi_clk  = sck_q;
   assign spi_mosi = mosi_q;
   assign spi_dc   = dc_q;
   assign spi_cs_n = cs_n_q;

endmodule

// File: tb/tb_tft_spi_tx_fifo.sv
// Bench for tft_spi_tx_fifo: queue/countdown reference model, per-cycle pin prediction and an SPI
// byte decoder feeding a scoreboard of accepted entries.
module tb_tft_spi_tx_fifo;
   localparam int unsigned DL        = 4;
   localparam int unsigned DV        = 4;
   localparam int          BYTE_CLKS = 16 * (DV + 1);
   localparam int          CAP       = 2 ** DL;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   tft_spi_tx_fifo_if #(.DEPTH_LOG2(DL)) bus ();
   tft_spi_tx_fifo_if #(.DEPTH_LOG2(DL)) bus0 ();
   logic sck, mosi, dc, cs_n;
   logic sck0, mosi0, dc0, cs_n0;

   tft_spi_tx_fifo #(.DEPTH_LOG2(DL), .DIV(DV)) dut (
      .clk(clk), .reset_n(reset_n), .host(bus),
      .spi_clk(sck), .spi_mosi(mosi), .spi_dc(dc), .spi_cs_n(cs_n)
   );

   tft_spi_tx_fifo #(.DEPTH_LOG2(DL), .DIV(0)) dut0 (
      .clk(clk), .reset_n(reset_n), .host(bus0),
      .spi_clk(sck0), .spi_mosi(mosi0), .spi_dc(dc0), .spi_cs_n(cs_n0)
   );

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: FIFO contents, whether a byte is on the wire, and clocks left in that byte.
   logic [8:0] fifo_m[$];
   logic [8:0] sb_q[$];
   bit         busy_m = 1'b0;
   int         rem_m  = 0;
   logic [8:0] cur_m  = '0;
   bit         ovf_m  = 1'b0;

   always @(posedge clk) begin : model
      int sz;
      bit full;
      bit do_pop;
      sz     = fifo_m.size();
      full   = (sz == CAP);
      do_pop = 1'b0;
      if (!reset_n) begin
         fifo_m.delete();
         sb_q.delete();
         busy_m = 1'b0;
         rem_m  = 0;
         ovf_m  = 1'b0;
      end else begin
         if (!busy_m) begin
            if (sz > 0) do_pop = 1'b1;
         end else begin
            rem_m--;
            if (rem_m == 0) begin
               if (sz > 0) do_pop = 1'b1;
               else busy_m = 1'b0;
            end
         end
         if (do_pop) begin
            cur_m  = fifo_m.pop_front();
            busy_m = 1'b1;
            rem_m  = BYTE_CLKS;
         end
         if (bus.wr_valid && !full) begin
            fifo_m.push_back(bus.wr_data);
            sb_q.push_back(bus.wr_data);
         end
         if (bus.clr_ovf) ovf_m = 1'b0;
         else if (bus.wr_valid && full) ovf_m = 1'b1;
      end
   end

   // Per-cycle prediction of status and SPI pins from elapsed time within the current byte.
   always @(negedge clk) begin : pins
      int         e;
      int         sz;
      logic [9:0] exp_v;
      logic [9:0] act_v;
      if (chk_en) begin
         sz    = fifo_m.size();
         e     = BYTE_CLKS - rem_m;
         exp_v = {5'(sz), sz < CAP, !busy_m && sz == 0, ovf_m, !busy_m,
                  busy_m && ((e / (DV + 1)) % 2 == 1)};
         act_v = {bus.level, bus.wr_ready, bus.idle, bus.overflow, cs_n, sck};
         chk("status{level,rdy,idle,ovf,cs_n,sck}", 32'(act_v), 32'(exp_v));
         if (busy_m) begin
            chk("pins{dc,mosi}", 32'({dc, mosi}),
                32'({cur_m[8], cur_m[7 - e / (2 * (DV + 1))]}));
         end
      end
   end

   // Monitor: decode bytes on SCK rises while CS is low and check them against the scoreboard.
   logic       prev_sck;
   int         nbits = 0;
   logic [7:0] sh_byte;
   logic       dc_cap;

   always @(negedge clk) begin : monitor
      logic [8:0] exp_e;
      if (!chk_en || cs_n !== 1'b0) begin
         nbits = 0;
      end else if (prev_sck === 1'b0 && sck === 1'b1) begin
         sh_byte = {sh_byte[6:0], mosi};
         dc_cap  = dc;
         nbits++;
         if (nbits == 8) begin
            nbits = 0;
            if (sb_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL spi_byte: got %0h, required nothing pending", {dc_cap, sh_byte});
            end else begin
               exp_e = sb_q.pop_front();
               chk("spi_byte{dc,data}", 32'({dc_cap, sh_byte}), 32'(exp_e));
            end
         end
      end
      prev_sck = sck;
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic push1(input logic [8:0] d);
      bus.wr_valid = 1'b1;
      bus.wr_data  = d;
      @(negedge clk);
      bus.wr_valid = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int k;
      k = 0;
      while (!(bus.idle === 1'b1 && cs_n === 1'b1) && k < budget) begin
         @(negedge clk);
         k++;
      end
      chk("wait_idle_timeout", 32'(k < budget), 32'd1);
   endtask

   initial begin : watchdog
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish, required finish");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int rises;
      int k;
      int thr;
      logic p;

      bus.wr_valid  = 1'b0;
      bus.wr_data   = '0;
      bus.clr_ovf   = 1'b0;
      bus0.wr_valid = 1'b0;
      bus0.wr_data  = '0;
      bus0.clr_ovf  = 1'b0;
      cyc(3);
      reset_n = 1'b1;
      chk_en  = 1'b1;
      chk("reset{sck,cs_n,mosi,dc}", 32'({sck, cs_n, mosi, dc}), 32'b0100);
      chk("reset_level", 32'(bus.level), 32'd0);
      chk("reset{ovf,idle,rdy}", 32'({bus.overflow, bus.idle, bus.wr_ready}), 32'b011);

      // Single command/data byte, CS falls two clocks after the push.
      push1(9'h1A5);
      chk("t1_cs_after_push", 32'(cs_n), 32'd1);
      cyc(1);
      chk("t1_cs_fall", 32'(cs_n), 32'd0);
      chk("t1_dc", 32'(dc), 32'd1);
      wait_idle(400);

      // Back-to-back burst with a command then data.
      bus.wr_valid = 1'b1;
      bus.wr_data = 9'h02A; @(negedge clk);
      bus.wr_data = 9'h100; @(negedge clk);
      bus.wr_data = 9'h1EF; @(negedge clk);
      bus.wr_valid = 1'b0;
      wait_idle(600);

      // 18 consecutive pushes: 17 accepted, last one overflows.
      for (int i = 0; i < 18; i++) begin
         bus.wr_valid = 1'b1;
         bus.wr_data  = 9'($urandom);
         @(negedge clk);
      end
      bus.wr_valid = 1'b0;
      chk("t3_level_full", 32'(bus.level), 32'd16);
      chk("t3_{rdy,ovf}", 32'({bus.wr_ready, bus.overflow}), 32'b01);
      bus.clr_ovf = 1'b1;
      @(negedge clk);
      bus.clr_ovf = 1'b0;
      chk("t3_ovf_cleared", 32'(bus.overflow), 32'd0);
      wait_idle(17 * BYTE_CLKS + 100);

      // Keep pushing against a full FIFO while the shifter pops.
      for (int i = 0; i < 220; i++) begin
         bus.wr_valid = 1'b1;
         bus.wr_data  = 9'($urandom);
         @(negedge clk);
      end
      bus.wr_valid = 1'b0;
      bus.clr_ovf  = 1'b1;
      @(negedge clk);
      bus.clr_ovf  = 1'b0;
      wait_idle(18 * BYTE_CLKS + 100);

      // Random traffic at varying push densities.
      for (int blk = 0; blk < 6; blk++) begin
         thr = int'($urandom_range(1, 9));
         for (int c = 0; c < 500; c++) begin
            bus.wr_valid = ($urandom_range(0, 9) < thr);
            bus.wr_data  = 9'($urandom);
            bus.clr_ovf  = ($urandom_range(0, 63) == 0);
            @(negedge clk);
         end
      end
      bus.wr_valid = 1'b0;
      bus.clr_ovf  = 1'b0;
      wait_idle(18 * BYTE_CLKS + 100);

      // Reset one clock after the third SCK rise of a burst.
      push1(9'h0C3);
      push1(9'h13C);
      rises = 0;
      k     = 0;
      p     = 1'b0;
      while (rises < 3 && k < 200) begin
         @(negedge clk);
         if (!p && sck) rises++;
         p = sck;
         k++;
      end
      chk("t5_third_rise", 32'(rises), 32'd3);
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      chk("t5_{cs_n,sck,idle}", 32'({cs_n, sck, bus.idle}), 32'b101);
      chk("t5_level", 32'(bus.level), 32'd0);
      cyc(40);
      push1(9'h15A);
      wait_idle(400);

      // DIV=0 instance: SCK toggles every clock, byte done in 16 clocks.
      bus0.wr_data  = 9'h0FF;
      bus0.wr_valid = 1'b1;
      @(negedge clk);
      bus0.wr_valid = 1'b0;
      chk("t6_cs_before", 32'(cs_n0), 32'd1);
      @(negedge clk);
      for (int i = 0; i < 16; i++) begin
         chk("t6_{sck,mosi,dc,cs_n}", 32'({sck0, mosi0, dc0, cs_n0}), 32'({i[0], 3'b100}));
         @(negedge clk);
      end
      chk("t6_end{sck,cs_n,idle}", 32'({sck0, cs_n0, bus0.idle}), 32'b011);

      cyc(5);
      chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
